ws2812b_serializer: RTL and testbench
=====================================

Name: ws2812b_serializer

Overview:
- Downstream stage of the TinyQV WS2812B driver peripheral.
- Accepts one 24-bit GRB pixel per valid/ready handshake and serialises it MSB-first onto a single NRZ line using WS2812B bit timing.
- Optionally follows the pixel with a latch (reset) low period so the strip displays the frame.
- Pure cycle-count timing; defaults assume the 64 MHz TinyQV clock.

Parameters:
T0H_CYC, 26, high time of a '0' bit in clk cycles (~0.40 us)
T1H_CYC, 51, high time of a '1' bit in clk cycles (~0.80 us)
BIT_CYC, 80, total bit period in clk cycles (1.25 us); required: T0H_CYC < T1H_CYC < BIT_CYC
RES_CYC, 19200, latch/reset low time in clk cycles (300 us, valid for new and old WS2812B parts)

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
data_in  in  24  pixel {G[7:0],R[7:0],B[7:0]}, sampled on acceptance
valid  in  1  pixel offered; accepted on a rising edge where valid & ready
latch  in  1  sampled with data_in; 1 = append RES_CYC low period after this pixel
ready  out  1  registered; 1 = idle, next pixel can be accepted
led  out  1  registered serial output to strip DIN

Behaviour:
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Reset (edge with rst_n=0):
  - state=RES, led=0, ready=0, bit index=23, timer=0.
  - The block then holds led low for RES_CYC cycles before first asserting ready, so the strip is resynchronised after every reset.
- States:
  - IDLE: led=0, ready=1. On valid=1, capture data_in into a shift register and latch into a latch_pending flag, load the timer, go to HIGH. ready=0 from the next cycle.
  - HIGH: led=1 for T1H_CYC cycles if the current bit is 1, else T0H_CYC cycles, then go to LOW.
  - LOW: led=0 for the remainder of BIT_CYC. At the end of the period:
    - if bit index > 0: decrement the index, shift the register, go to HIGH;
    - else if latch_pending: go to RES;
    - else: go to IDLE.
  - RES: led=0 for RES_CYC cycles, then go to IDLE.
- Cycle timing: if acceptance happens at edge E, led is 1 from E+1. Each bit occupies exactly BIT_CYC cycles. Bit 23 (G7) is sent first and bit 0 (B0) last. ready rises exactly 24*BIT_CYC cycles after E without latch, or 24*BIT_CYC+RES_CYC cycles after E with latch.
- Handshake:
  - ready drops the cycle after acceptance. This is mandatory: upstream clears valid when it sees ready=0.
  - valid while ready=0 is ignored. data_in and latch are don't-care outside the acceptance edge.
- Back-to-back pixels: upstream may re-offer within a few cycles of ready rising. That extends the last bit's low time by the upstream latency (typically 2 cycles, must be under ~9 cycles at 64 MHz), which is within WS2812B tolerance. No other inter-pixel gap is inserted.
- Timer:
  - width is $clog2(max(BIT_CYC,RES_CYC)+1);
  - counts down to 1;
  - never wraps; terminal count triggers the state transition in the same cycle.
- Reset mid-frame (any state): immediate return to the RES sequence. led=0 on the next edge; the partial pixel is dropped.
- valid asserted in the same cycle that ready first rises: accepted normally.

Decomposition:
- Package ws2812b_pkg holds:
  - state enum (IDLE, HIGH, LOW, RES);
  - default timing constants for 64 MHz (T0H/T1H/BIT/RES);
  - a PIXEL_W=24 constant.
- Single module; no sub-module needed.
- The timer and the shift register are inline.

Test Plan:
- Use T0H=2, T1H=5, BIT=8, RES=20 for speed unless stated.
- Reset release: led=0 and ready=0 for exactly 20 cycles, then ready=1; a valid during that window is ignored.
- Pixel 24'hA50000 with latch=0: led high widths 5,2,5,2,2,5,2,5 on bits 23..16, then 16 bits of width 2; every bit period is 8 cycles; ready=1 exactly 192 cycles after acceptance and no RES period follows.
- Pixel 24'h000001 with latch=1: 23 short pulses, one long pulse, then led=0 for 20 cycles; ready rises at acceptance+212.
- Back-to-back 24'hFFFFFF and 24'h000000 offered 2 cycles after ready: the second pixel starts within 3 cycles of ready rising, and ready pulses low for one cycle after each acceptance.
- rst_n=0 during bit 10 of a pixel: led=0 on the next edge, followed by the 20-cycle RES period, then ready=1; no stray high pulse.
- Default parameters at 64 MHz: bit 1 high=51 cycles, bit 0 high=26 cycles, period=80 cycles, latch=19200 cycles, checked against the WS2812B datasheet window.

Source files
------------

// File: rtl/ws2812b_serializer_pkg.sv
// Shared types and default 64 MHz timing for the WS2812B serializer.
package ws2812b_pkg;

  localparam int unsigned PIXEL_W = 24;

  // Defaults for the 64 MHz TinyQV clock
  localparam int unsigned T0H_CYC_DEF = 26;     // ~0.40 us
  localparam int unsigned T1H_CYC_DEF = 51;     // ~0.80 us
  localparam int unsigned BIT_CYC_DEF = 80;     // 1.25 us
  localparam int unsigned RES_CYC_DEF = 19200;  // 300 us latch

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2,
    RES  = 2'd3
  } state_e;

endpackage

// File: rtl/ws2812b_serializer_if.sv
// Pixel handshake between the upstream driver and the serializer.
interface ws2812b_serializer_if;
  import ws2812b_pkg::*;

  logic [PIXEL_W-1:0] data_in;
  logic               valid;
  logic               latch;
  logic               ready;

  modport master (output data_in, output valid, output latch, input ready);
  modport slave  (input data_in, input valid, input latch, output ready);
endinterface

// File: rtl/ws2812b_serializer.sv
// Serialises one GRB pixel MSB-first onto the WS2812B NRZ line, with an
// optional latch low period afterwards. Timing is pure cycle counting.
// Parameters must satisfy T0H_CYC < T1H_CYC < BIT_CYC and RES_CYC >= 1.
module ws2812b_serializer
  import ws2812b_pkg::*;
#(
  parameter int unsigned T0H_CYC = T0H_CYC_DEF,
  parameter int unsigned T1H_CYC = T1H_CYC_DEF,
  parameter int unsigned BIT_CYC = BIT_CYC_DEF,
  parameter int unsigned RES_CYC = RES_CYC_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ws2812b_serializer_if.slave  bus,
  output logic                 led
);

  localparam int unsigned MAX_CYC = (BIT_CYC > RES_CYC) ? BIT_CYC : RES_CYC;
  localparam int unsigned TW      = $clog2(MAX_CYC + 1);
  localparam int unsigned IDX_W   = $clog2(PIXEL_W);

  state_e               state_q;
  logic [TW-1:0]        timer_q;
  logic [IDX_W-1:0]     idx_q;
  logic [PIXEL_W-1:0]   shift_q;
  logic                 latch_q;
  logic                 led_q;
  logic                 ready_q;
  logic [TW-1:0]        res_rem_c;

  // High time for a bit value
  function automatic logic [TW-1:0] high_cyc(input logic b);
    return b ? TW'(T1H_CYC) : TW'(T0H_CYC);
  endfunction

  // Low remainder of the bit period after the high phase
  function automatic logic [TW-1:0] low_cyc(input logic b);
    return b ? TW'(BIT_CYC - T1H_CYC) : TW'(BIT_CYC - T0H_CYC);
  endfunction

  // Timer 0 in RES means we arrived from reset: treat as a fresh full period
  assign res_rem_c = (timer_q == '0) ? TW'(RES_CYC) : timer_q;

  // Single-process FSM: timer, shift register and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RES;
      timer_q <= '0;
      idx_q   <= IDX_W'(PIXEL_W - 1);
      shift_q <= '0;
      latch_q <= 1'b0;
      led_q   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          led_q <= 1'b0;
          if (bus.valid) begin
            shift_q <= bus.data_in;
            latch_q <= bus.latch;
            idx_q   <= IDX_W'(PIXEL_W - 1);
            timer_q <= high_cyc(bus.data_in[PIXEL_W-1]);
            led_q   <= 1'b1;
            ready_q <= 1'b0;
            state_q <= HIGH;
          end
        end
        HIGH: begin
          if (timer_q == TW'(1)) begin
            led_q   <= 1'b0;
            timer_q <= low_cyc(shift_q[PIXEL_W-1]);
            state_q <= LOW;
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        LOW: begin
          if (timer_q == TW'(1)) begin
            if (idx_q != '0) begin
              idx_q   <= idx_q - IDX_W'(1);
              shift_q <= {shift_q[PIXEL_W-2:0], 1'b0};
              timer_q <= high_cyc(shift_q[PIXEL_W-2]);
              led_q   <= 1'b1;
              state_q <= HIGH;
            end else if (latch_q) begin
              timer_q <= TW'(RES_CYC);
              state_q <= RES;
            end else begin
              timer_q <= '0;
              ready_q <= 1'b1;
              state_q <= IDLE;
            end
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        RES: begin
          led_q <= 1'b0;
          if (res_rem_c == TW'(1)) begin
            timer_q <= '0;
            ready_q <= 1'b1;
            state_q <= IDLE;
          end else begin
            timer_q <= res_rem_c - TW'(1);
          end
        end
        default: begin
          led_q   <= 1'b0;
          ready_q <= 1'b0;
          timer_q <= '0;
          state_q <= RES;
        end
      endcase
    end
  end

  assign led       = led_q;
  assign bus.ready = ready_q;

endmodule

// File: tb/tb_ws2812b_serializer.sv
// Scoreboard bench: stimulus queues expected pulse widths, bit periods and
// ready-rise cycles; a monitor pops and compares as the line toggles.
module tb_ws2812b_serializer;
  import ws2812b_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst2_n = 1'b0;
  logic led, led2;

  always #5 clk = ~clk;

  ws2812b_serializer_if bus ();
  ws2812b_serializer_if bus2 ();

  ws2812b_serializer #(
    .T0H_CYC(2), .T1H_CYC(5), .BIT_CYC(8), .RES_CYC(20)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .led(led)
  );

  ws2812b_serializer dut2 (
    .clk(clk), .rst_n(rst2_n), .bus(bus2), .led(led2)
  );

  typedef struct {
    int hi;
    int per;
  } pulse_t;

  pulse_t exp_pulse[$];
  int     exp_ready[$];

  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  logic discard = 1'b0;
  int   ready2_rise = -1;

  task automatic chk(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Cycle counter, read only on negedges
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: pulse widths, bit periods, ready rises
  initial begin
    logic   led_prev = 1'b0;
    logic   rdy_prev = 1'b0;
    logic   rdy2_prev = 1'b0;
    int     rise_cyc = 0;
    int     prev_rise = 0;
    int     pend_per = 0;
    pulse_t p;
    forever begin
      @(negedge clk);
      if (led && !led_prev) begin
        if (pend_per != 0) chk("bit_period", cyc - prev_rise, pend_per);
        pend_per = 0;
        rise_cyc = cyc;
      end
      if (!led && led_prev) begin
        if (discard) begin
          discard = 1'b0;
          pend_per = 0;
        end else if (exp_pulse.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL stray_pulse: width %0d at cycle %0d, required no pulse",
                   cyc - rise_cyc, cyc);
        end else begin
          p = exp_pulse.pop_front();
          chk("high_width", cyc - rise_cyc, p.hi);
          pend_per  = p.per;
          prev_rise = rise_cyc;
        end
      end
      if (bus.ready && !rdy_prev) begin
        if (exp_ready.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL stray_ready: rose at cycle %0d, required no rise", cyc);
        end else begin
          chk("ready_rise", cyc, exp_ready.pop_front());
        end
      end
      if (bus2.ready && !rdy2_prev) ready2_rise = cyc;
      led_prev  = led;
      rdy_prev  = bus.ready;
      rdy2_prev = bus2.ready;
    end
  end

  task automatic wait_ready(input int limit);
    int n = 0;
    while (!bus.ready && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (!bus.ready) begin
      n_vec++;
      n_err++;
      $display("FAIL ready_timeout: ready=0 after %0d cycles, required 1", limit);
    end
  endtask

  // Offer a pixel `gap` cycles after ready is seen; queue its expectations
  task automatic send(input logic [23:0] d, input logic l, input int gap);
    int     e;
    pulse_t p;
    wait_ready(400);
    repeat (gap) @(negedge clk);
    e = cyc + 1;
    for (int i = 23; i >= 0; i--) begin
      p.hi  = d[i] ? 5 : 2;
      p.per = (i == 0) ? 0 : 8;
      exp_pulse.push_back(p);
    end
    exp_ready.push_back(e + 192 + (l ? 20 : 0));
    bus.data_in = d;
    bus.latch   = l;
    bus.valid   = 1'b1;
    @(negedge clk);
    bus.valid   = 1'b0;
    bus.data_in = 24'($urandom);
    bus.latch   = 1'($urandom);
    chk("ready_drop", int'(bus.ready), 0);
    chk("led_start", int'(led), 1);
  endtask

  task automatic meas2(input logic lvl, output int n);
    n = 0;
    while (led2 == lvl && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  function automatic int in_win(input int cycles, input int lo_ns, input int hi_ns);
    int ns = cycles * 15625 / 1000;
    return (ns >= lo_ns && ns <= hi_ns) ? 1 : 0;
  endfunction

  initial begin
    int r0, e, e2, n1, n0, nz, lim;
    bus.valid = 1'b0;  bus.data_in = '0;  bus.latch = 1'b0;
    bus2.valid = 1'b0; bus2.data_in = '0; bus2.latch = 1'b0;

    repeat (3) @(negedge clk);
    chk("reset_led", int'(led), 0);
    chk("reset_ready", int'(bus.ready), 0);
    rst_n  = 1'b1;
    rst2_n = 1'b1;
    r0 = cyc;
    exp_ready.push_back(r0 + 20);

    // valid during the post-reset latch window must be ignored
    bus.data_in = 24'hFFFFFF;
    bus.latch   = 1'b1;
    bus.valid   = 1'b1;
    repeat (5) @(negedge clk);
    bus.valid = 1'b0;
    repeat (r0 + 19 - cyc) @(negedge clk);
    chk("res_window_ready", int'(bus.ready), 0);
    chk("res_window_led", int'(led), 0);
    wait_ready(40);

    send(24'hA50000, 1'b0, 0);
    send(24'h000001, 1'b1, 0);
    send(24'hFFFFFF, 1'b0, 2);
    send(24'h000000, 1'b0, 2);

    // Reset in the middle of bit 10 of an all-ones pixel
    send(24'hFFFFFF, 1'b1, 0);
    e = cyc;
    repeat (106) @(negedge clk);
    chk("midreset_led_high", int'(led), 1);
    exp_pulse.delete();
    exp_ready.delete();
    discard = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("midreset_led", int'(led), 0);
    chk("midreset_ready", int'(bus.ready), 0);
    rst_n = 1'b1;
    exp_ready.push_back(cyc + 20);
    if (cyc != e + 107) chk("midreset_cycle", cyc, e + 107);
    wait_ready(40);

    send(24'h3C00C3, 1'b0, 1);
    wait_ready(400);
    repeat (4) @(negedge clk);
    chk("leftover_pulses", exp_pulse.size(), 0);
    chk("leftover_ready", exp_ready.size(), 0);

    // Default 64 MHz timing on the second instance
    lim = 0;
    while (!bus2.ready && lim < 25000) begin
      @(negedge clk);
      lim++;
    end
    chk("def_reset_to_ready", ready2_rise, r0 + 19200);
    bus2.data_in = 24'h800000;
    bus2.latch   = 1'b1;
    bus2.valid   = 1'b1;
    e2 = cyc + 1;
    @(negedge clk);
    bus2.valid = 1'b0;
    chk("def_led_start", int'(led2), 1);
    meas2(1'b1, n1);
    meas2(1'b0, n0);
    meas2(1'b1, nz);
    chk("def_t1h", n1, 51);
    chk("def_bit", n1 + n0, 80);
    chk("def_t0h", nz, 26);
    chk("def_t1h_window", in_win(n1, 650, 950), 1);
    chk("def_t0h_window", in_win(nz, 250, 550), 1);
    chk("def_bit_window", in_win(n1 + n0, 650, 1850), 1);
    lim = 0;
    while ((ready2_rise < e2) && lim < 25000) begin
      @(negedge clk);
      lim++;
    end
    chk("def_latch_ready", ready2_rise - e2, 24 * 80 + 19200);
    chk("def_latch_window", in_win(ready2_rise - e2 - 24 * 80, 280000, 2000000), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
